// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit (master) and the memory (slave).
`default_nettype none

interface if_fetch_unit_if;
    logic        read;
    logic [31:0] addr;
    logic [31:0] readdata;
    logic        busywait;

    modport master (
        output read,
        output addr,
        input  readdata,
        input  busywait
    );

    modport slave (
        input  read,
        input  addr,
        output readdata,
        output busywait
    );
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// RV32IM instruction-fetch stage: PC ownership, imem handshake, stall/redirect handling.
// Optional macro IF_PERF_CNT_EN adds fetch_count/stall_count performance counters.
`default_nettype none

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            pc_out,
    output logic [31:0]            pc_plus4_out,
    output logic [31:0]            instr_out,
    output logic                   instr_valid,
    output logic                   busywait
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            stall_count
`endif
);

    typedef enum logic [0:0] {
        ACCESS  = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pend_pc, pend_next;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ACCESS;
            pc_reg  <= RESET_PC;
            pend_pc <= 32'h0000_0000;
        end else begin
            state   <= state_next;
            pc_reg  <= pc_next;
            pend_pc <= pend_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc_reg;
        pend_next    = pend_pc;
        imem.read    = 1'b1;
        imem.addr    = pc_reg;
        pc_out       = pc_reg;
        pc_plus4_out = pc_reg + 32'd4;
        instr_out    = NOP_INSTR;
        instr_valid  = 1'b0;
        busywait     = 1'b0;

        case (state)
            ACCESS: begin
                busywait = imem.busywait;
                if (!imem.busywait) begin
                    if (redirect) begin
                        pc_next = redirect_tgt;
                    end else begin
                        instr_out   = imem.readdata;
                        instr_valid = 1'b1;
                        if (!stall) begin
                            pc_next = pc_reg + 32'd4;
                        end
                    end
                end else if (redirect) begin
                    pend_next  = redirect_tgt;
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                // The old request stays on the bus until memory finishes; its data is dropped.
                busywait = 1'b1;
                if (redirect) begin
                    pend_next = redirect_tgt;
                end
                if (!imem.busywait) begin
                    pc_next    = pend_next;
                    state_next = ACCESS;
                end
            end
            default: begin
                state_next = ACCESS;
            end
        endcase

        // Reset is asynchronous, so the handshake outputs must be quiet the moment rst drops.
        if (!rst) begin
            imem.read   = 1'b0;
            instr_out   = NOP_INSTR;
            instr_valid = 1'b0;
            busywait    = 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= 32'h0000_0000;
            stall_count <= 32'h0000_0000;
        end else begin
            if (instr_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (busywait || stall) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, reset corners, randomized model check.
`default_nettype none

module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_out, pc_plus4_out, instr_out;
    logic        instr_valid, busywait;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    int total = 0;
    int passed = 0;

    if_fetch_unit_if imem ();

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem         (imem),
        .pc_out       (pc_out),
        .pc_plus4_out (pc_plus4_out),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .busywait     (busywait)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        busy;
        logic [31:0] addr;
        logic        valid;
        logic        bw;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[31:16]};
    endfunction

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp, input logic b,
                                input logic [31:0] a, input logic v, input logic w);
        vec_t t;
        t.stall = s; t.redirect = r; t.rpc = rp; t.busy = b;
        t.addr = a; t.valid = v; t.bw = w;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Apply one cycle of inputs at the falling edge; memory answers for whatever address is on the bus.
    task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic b);
        @(negedge clk);
        stall = s; redirect = r; redirect_pc = rp; imem.busywait = b;
        #1;
        imem.readdata = mem_word(imem.addr);
        #1;
    endtask

    task automatic check_cycle(input string tag, input logic [31:0] a, input logic v, input logic w);
        chk({tag, ".imem_read"}, {31'b0, imem.read}, 32'd1);
        chk({tag, ".imem_addr"}, imem.addr, a);
        chk({tag, ".pc_out"}, pc_out, a);
        chk({tag, ".pc_plus4"}, pc_plus4_out, a + 32'd4);
        chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, v});
        chk({tag, ".busywait"}, {31'b0, busywait}, {31'b0, w});
        chk({tag, ".instr_out"}, instr_out, v ? mem_word(a) : NOP);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".imem_read"}, {31'b0, imem.read}, 32'd0);
        chk({tag, ".imem_addr"}, imem.addr, 32'h0);
        chk({tag, ".pc_out"}, pc_out, 32'h0);
        chk({tag, ".pc_plus4"}, pc_plus4_out, 32'h4);
        chk({tag, ".instr_out"}, instr_out, NOP);
        chk({tag, ".instr_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, ".busywait"}, {31'b0, busywait}, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk({tag, ".fetch_count"}, fetch_count, 32'd0);
        chk({tag, ".stall_count"}, stall_count, 32'd0);
`endif
    endtask

    // Reference model state: next word to fetch, whether the current access is being thrown away,
    // and the most recent redirect target waiting behind it.
    logic [31:0] m_pc, m_pend;
    logic        m_drop;
    logic [31:0] m_fetches, m_stalls;

    initial begin
        imem.busywait = 1'b1;
        imem.readdata = 32'h0;

        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0004, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0008, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0008, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0008, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0008, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0000_000C, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0000_0010, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0000_0010, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0010, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0014, 1, 0));
        tbl.push_back(mk(1, 1, 32'h0000_0203, 0, 32'h0000_0018, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0200, 1, 0));
        tbl.push_back(mk(0, 1, 32'h0000_0020, 0, 32'h0000_0204, 0, 0));
        tbl.push_back(mk(0, 1, 32'h0000_0400, 1, 32'h0000_0020, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0020, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0020, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0400, 1, 0));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0000_0404, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 32'h0000_0004, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0040, 0, 1));

        // Reset held with memory busy: handshake outputs must stay quiet.
        @(negedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].stall, tbl[i].redirect, tbl[i].rpc, tbl[i].busy);
            check_cycle($sformatf("vec%0d", i), tbl[i].addr, tbl[i].valid, tbl[i].bw);
        end

        // Asynchronous reset in the middle of the wait at 0x40.
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        #1;
        check_reset_outputs("midreset_hold");
        stall = 1'b0; redirect = 1'b0; imem.busywait = 1'b0;
        rst = 1'b1;
        #1;
        imem.readdata = mem_word(imem.addr);
        #1;
        check_cycle("after_reset", 32'h0, 1'b1, 1'b0);

        // Fresh reset, then randomized traffic against the reference model.
        @(negedge clk);
        imem.busywait = 1'b1; redirect = 1'b0; stall = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        m_pc = 32'h0; m_pend = 32'h0; m_drop = 1'b0;
        m_fetches = 32'h0; m_stalls = 32'h0;

        for (int c = 0; c < 600; c++) begin
            logic        s, r, b, ev, ew;
            logic [31:0] rp, tgt;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 6) == 0);
            b  = ($urandom_range(0, 2) == 0);
            rp = $urandom;
            tgt = {rp[31:2], 2'b00};
            step(s, r, rp, b);

            ew = m_drop ? 1'b1 : b;
            ev = !m_drop && !b && !r;
            check_cycle($sformatf("rnd%0d", c), m_pc, ev, ew);
`ifdef IF_PERF_CNT_EN
            chk($sformatf("rnd%0d.fetch_count", c), fetch_count, m_fetches);
            chk($sformatf("rnd%0d.stall_count", c), stall_count, m_stalls);
`endif
            if (ev) m_fetches = m_fetches + 32'd1;
            if (ew || s) m_stalls = m_stalls + 32'd1;

            if (m_drop) begin
                if (r) m_pend = tgt;
                if (!b) begin
                    m_pc = m_pend;
                    m_drop = 1'b0;
                end
            end else if (!b) begin
                if (r) m_pc = tgt;
                else if (!s) m_pc = m_pc + 32'd4;
            end else if (r) begin
                m_pend = tgt;
                m_drop = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the RV32IM pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC, runs the instruction-memory read handshake, and applies stall and branch/jump redirects.
- Presents pc_out, pc_plus4_out, instr_out and instr_valid for IF/ID to sample.
- Drives busywait, which freezes IF/ID and the downstream pipeline registers while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction injected on a squashed fetch (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- stall  in  1  hazard-unit hold: PC not advanced.
- redirect  in  1  branch taken / jump from EX; may be a single-cycle pulse.
- redirect_pc  in  32  redirect target.
- imem_read  out  1  instruction memory read request.
- imem_addr  out  32  instruction memory word address.
- imem_readdata  in  32  instruction word; valid when imem_busywait=0.
- imem_busywait  in  1  memory busy; asserted in the same cycle as the request while pending.
- pc_out  out  32  PC of the presented instruction.
- pc_plus4_out  out  32  pc_out+4, used as the link value.
- instr_out  out  32  fetched instruction, or NOP_INSTR.
- instr_valid  out  1  1 = instr_out is a real fetched instruction.
- busywait  out  1  pipeline freeze to IF/ID and later stages.

Behaviour:
- State: pc_reg (32), pend_pc (32), FSM {ACCESS, DISCARD}.
- Reset (rst=0, asynchronous): pc_reg=RESET_PC, pend_pc=0, state=ACCESS.
- Outputs held during reset: imem_read=0, imem_addr=RESET_PC, pc_out=RESET_PC, pc_plus4_out=RESET_PC+4, instr_out=NOP_INSTR, instr_valid=0, busywait=0.
- Reset mid-access: the in-flight access is abandoned; the first fetch after release is RESET_PC.
- ACCESS, memory interface: imem_read=1, imem_addr=pc_reg, busywait=imem_busywait.
- ACCESS, pipeline outputs are combinational: pc_out=pc_reg, pc_plus4_out=pc_reg+4 (mod 2^32).
- ACCESS, completion (imem_busywait=0): instr_out=imem_readdata and instr_valid=1, unless redirect=1 in that cycle, in which case instr_out=NOP_INSTR and instr_valid=0.
- ACCESS, next pc_reg on completion, in priority order:
  - redirect -> {redirect_pc[31:2],2'b00}
  - else stall -> pc_reg (same word re-fetched next cycle)
  - else pc_reg+4
- ACCESS, pending (imem_busywait=1):
  - instr_out=NOP_INSTR, instr_valid=0; pc_reg holds.
  - If redirect=1: pend_pc={redirect_pc[31:2],2'b00}, next state DISCARD.
- DISCARD: imem_read=1 and imem_addr=pc_reg (the old request is kept stable until memory finishes); busywait=1; instr_valid=0; instr_out=NOP_INSTR.
- DISCARD, on imem_busywait=0: the returned data is dropped; pc_reg=pend_pc; next state ACCESS.
- DISCARD, further redirects: a later redirect in DISCARD overwrites pend_pc (newest wins).
- Boundary and ordering rules:
  - redirect beats stall.
  - pc_reg wrap-around: 32'hFFFF_FFFC+4 -> 32'h0000_0000.
  - redirect_pc[1:0] is ignored.
  - Zero-wait memory (imem_busywait never asserted) gives one instruction per cycle, with no bubble except on redirect.
- Latency: redirect asserted in cycle N -> target fetch presented in cycle N+1 when memory is idle, otherwise one cycle after the discarded access completes.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds two outputs:
  - fetch_count (32): increments on every completion with instr_valid=1.
  - stall_count (32): increments every cycle busywait=1 or stall=1.
  - Both reset to 0 on rst=0 and wrap at 2^32.
- When undefined, neither port nor counter exists, and the behaviour is otherwise identical.

Test Plan:
- Reset release, imem_busywait=0 -> imem_addr/pc_out go 0x0, 0x4, 0x8, 0xC on consecutive cycles; instr_valid=1 each cycle; instr_out echoes imem_readdata.
- imem_busywait=1 for 3 cycles at pc 0x8 -> busywait=1 and instr_valid=0 for 3 cycles, imem_addr stable at 0x8; then 0x8's instruction presented and pc advances to 0xC.
- stall=1 for 2 cycles at pc 0x10, zero-wait memory -> imem_addr stays 0x10 for 3 cycles; next fetch is 0x14.
- redirect pulse with redirect_pc=0x200 and stall=1 in the same cycle -> that cycle instr_out=0x00000013, instr_valid=0; next imem_addr=0x200.
- redirect pulse to 0x400 while memory busy at 0x20 -> state DISCARD, busywait=1 until done, 0x20's data never valid; next imem_addr=0x400.
- Async reset asserted mid-wait at pc 0x40 -> immediately imem_read=0 and instr_valid=0; after release, first fetch 0x0. With IF_PERF_CNT_EN, both counters read 0 after reset.
